// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Serial bitstream loader for one configuration-chain segment. Parallel
//   config words arrive on a valid/ready stream and are shifted into
//   ccff_head LSB first. ccff_shift_en is high on exactly the cycles where
//   the chain must advance. After CHAIN_LEN shifted bits, done pulses once.
//   Optional readback of the old chain contents: define CCFF_READBACK_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  // word_left has to hold values 0..WORD_W
  localparam int WL_W = $clog2(WORD_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [WL_W-1:0]   word_left, word_left_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic              cnt_last;

  // Bit counter increment that sticks at CHAIN_LEN instead of wrapping
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_W'(CHAIN_LEN))
      return cnt;
    else
      return cnt + CNT_W'(1);
  endfunction

  // Bits to take from the next word: a full word, or whatever the chain still lacks
  function automatic logic [WL_W-1:0] word_take(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] rem;
    rem = CNT_W'(CHAIN_LEN) - cnt;
    if (32'(rem) >= 32'(WORD_W))
      return WL_W'(WORD_W);
    else
      return WL_W'(rem);
  endfunction

  assign cnt_last = (cnt_inc(bit_cnt) == CNT_W'(CHAIN_LEN));

  // Next-state logic for the load FSM and its datapath
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    word_left_n = word_left;
    shreg_n     = shreg;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_n   = ST_LOAD;
          bit_cnt_n = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (s_valid && s_ready) begin
          shreg_n     = s_data;
          word_left_n = word_take(bit_cnt);
          state_n     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else begin
          shreg_n     = shreg >> 1;
          word_left_n = word_left - WL_W'(1);
          bit_cnt_n   = cnt_inc(bit_cnt);
          if (word_left <= WL_W'(1))
            state_n = cnt_last ? ST_DONE : ST_LOAD;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      word_left     <= '0;
      shreg         <= '0;
      s_ready       <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      word_left     <= word_left_n;
      shreg         <= shreg_n;
      s_ready       <= (state_n == ST_LOAD);
      ccff_head     <= (state_n == ST_SHIFT) ? shreg_n[0] : 1'b0;
      ccff_shift_en <= (state_n == ST_SHIFT);
      busy          <= (state_n != ST_IDLE);
      done          <= (state_n == ST_DONE);
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_shreg;
  logic [WL_W-1:0]   rb_cnt;
  logic [WORD_W-1:0] rb_word;
  logic              rb_last;

  // Tail bit lands at its final position, so a short last word is zero-padded
  assign rb_word = rb_shreg | (WORD_W'(ccff_tail) << rb_cnt);
  assign rb_last = (rb_cnt == WL_W'(WORD_W - 1)) || cnt_last;

  // Capture the old chain contents as they fall out of the tail
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      rb_shreg <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == ST_SHIFT && !abort) begin
        if (rb_last) begin
          rb_data  <= rb_word;
          rb_valid <= 1'b1;
          rb_shreg <= '0;
          rb_cnt   <= '0;
        end else begin
          rb_shreg <= rb_word;
          rb_cnt   <= rb_cnt + WL_W'(1);
        end
      end else if (state == ST_IDLE || abort) begin
        rb_shreg <= '0;
        rb_cnt   <= '0;
      end
    end
  end
`else
  logic unused_tail;

  assign unused_tail = ccff_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader
//   Directed bench for ccff_chain_loader. Two instances: a 48-bit chain and a
//   13-bit chain (partial final word). Each drives a behavioural chain model
//   that shifts on prog_clk while ccff_shift_en is high and feeds ccff_tail.
module tb_ccff_chain_loader;

  localparam int LA = 48;
  localparam int LB = 13;
  localparam int W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_start, a_abort, a_s_valid, a_s_ready, a_head, a_tail;
  logic         a_shift_en, a_busy, a_done, a_rb_valid;
  logic [W-1:0] a_s_data, a_rb_data;

  logic         b_start, b_abort, b_s_valid, b_s_ready, b_head, b_tail;
  logic         b_shift_en, b_busy, b_done, b_rb_valid;
  logic [W-1:0] b_s_data, b_rb_data;

  ccff_chain_loader #(.CHAIN_LEN(LA), .WORD_W(W)) dut (
    .prog_clk(clk), .pReset(rst), .start(a_start), .abort(a_abort),
    .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .ccff_head(a_head), .ccff_tail(a_tail), .ccff_shift_en(a_shift_en),
    .busy(a_busy), .done(a_done), .rb_data(a_rb_data), .rb_valid(a_rb_valid)
  );

  ccff_chain_loader #(.CHAIN_LEN(LB), .WORD_W(W)) dut13 (
    .prog_clk(clk), .pReset(rst), .start(b_start), .abort(b_abort),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .ccff_head(b_head), .ccff_tail(b_tail), .ccff_shift_en(b_shift_en),
    .busy(b_busy), .done(b_done), .rb_data(b_rb_data), .rb_valid(b_rb_valid)
  );

  // Chain models plus event logs
  logic [LA-1:0] chain_a = '0;
  logic [LB-1:0] chain_b = '0;
  logic [LA-1:0] pre_val = '0;
  logic          pre_req = 1'b0;
  bit            a_log [0:511];
  bit            b_log [0:63];
  logic [W-1:0]  a_rb_log [0:63];
  int a_nshift = 0, a_ndone = 0, a_nrb = 0;
  int b_nshift = 0, b_ndone = 0, b_nrb = 0;

  assign a_tail = chain_a[LA-1];
  assign b_tail = chain_b[LB-1];

  always @(posedge clk) begin
    if (pre_req) chain_a <= pre_val;
    else if (a_shift_en) chain_a <= {chain_a[LA-2:0], a_head};
    if (a_shift_en) begin
      a_log[a_nshift % 512] <= a_head;
      a_nshift <= a_nshift + 1;
    end
    if (a_done) a_ndone <= a_ndone + 1;
    if (a_rb_valid) begin
      a_rb_log[a_nrb % 64] <= a_rb_data;
      a_nrb <= a_nrb + 1;
    end
  end

  always @(posedge clk) begin
    if (b_shift_en) begin
      chain_b <= {chain_b[LB-2:0], b_head};
      b_log[b_nshift % 64] <= b_head;
      b_nshift <= b_nshift + 1;
    end
    if (b_done) b_ndone <= b_ndone + 1;
    if (b_rb_valid) b_nrb <= b_nrb + 1;
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] wa [0:5];

  task automatic test_reset();
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_s_valid = 0; a_s_data = '0;
    b_start = 0; b_abort = 0; b_s_valid = 0; b_s_data = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({a_s_ready, a_head, a_shift_en, a_busy, a_done, a_rb_valid} !== 6'b0)
      $display("FAIL reset_a_ctrl: got %b want 000000",
               {a_s_ready, a_head, a_shift_en, a_busy, a_done, a_rb_valid});
    else n_pass++;
    n_chk++;
    if (a_rb_data !== 8'h00) $display("FAIL reset_a_rbdata: got %h want 00", a_rb_data);
    else n_pass++;
    n_chk++;
    if ({b_s_ready, b_head, b_shift_en, b_busy, b_done, b_rb_valid} !== 6'b0)
      $display("FAIL reset_b_ctrl: got %b want 000000",
               {b_s_ready, b_head, b_shift_en, b_busy, b_done, b_rb_valid});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Full load on the 48-bit instance using words in wa; optional 5-cycle
  // s_valid gap before word index gap_idx
  task automatic feed_a(input string name, input int gap_idx);
    int t;
    logic prev;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    n_chk++;
    if ({a_s_ready, a_busy} !== 2'b11)
      $display("FAIL %s_start_latency: ready,busy=%b want 11", name, {a_s_ready, a_busy});
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (i == gap_idx) begin
        t = 0;
        while (a_s_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        for (int k = 0; k < 5; k++) begin
          n_chk++;
          if ({a_s_ready, a_shift_en} !== 2'b10)
            $display("FAIL %s_gap%0d: ready,shift_en=%b want 10", name, k, {a_s_ready, a_shift_en});
          else n_pass++;
          @(negedge clk);
        end
      end
      a_s_data = wa[i];
      a_s_valid = 1'b1;
      t = 0;
      while (a_s_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin
        n_chk++;
        $display("FAIL %s_ready_timeout: word %0d got no s_ready within 100 cycles", name, i);
      end
      @(negedge clk);
      a_s_valid = 1'b0;
      a_s_data = '0;
      if (i == 0) begin
        n_chk++;
        if ({a_shift_en, a_head} !== {1'b1, wa[0][0]})
          $display("FAIL %s_first_shift: shift_en,head=%b want %b", name,
                   {a_shift_en, a_head}, {1'b1, wa[0][0]});
        else n_pass++;
      end
    end
    t = 0;
    prev = a_shift_en;
    while (a_done !== 1'b1 && t < 200) begin prev = a_shift_en; @(negedge clk); t++; end
    n_chk++;
    if (t >= 200 || prev !== 1'b1 || a_shift_en !== 1'b0)
      $display("FAIL %s_done_timing: waited %0d, shift_en before=%b at=%b want done after last shift",
               name, t, prev, a_shift_en);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({a_done, a_busy} !== 2'b00)
      $display("FAIL %s_done_1cycle: done,busy=%b want 00", name, {a_done, a_busy});
    else n_pass++;
  endtask

  task automatic check_a_load(input string name, input int base, input int dbase,
                              input logic [47:0] exp_bits);
    logic [47:0] g;
    n_chk++;
    if (a_nshift - base !== 48) $display("FAIL %s_shift_count: got %0d want 48", name, a_nshift - base);
    else n_pass++;
    for (int k = 0; k < 48; k++) g[k] = a_log[(base + k) % 512];
    n_chk++;
    if (g !== exp_bits) $display("FAIL %s_head_order: got %h want %h", name, g, exp_bits);
    else n_pass++;
    n_chk++;
    if (a_ndone - dbase !== 1) $display("FAIL %s_done_count: got %0d want 1", name, a_ndone - dbase);
    else n_pass++;
  endtask

  task automatic test_full_load();
    int base, dbase;
    base = a_nshift; dbase = a_ndone;
    for (int i = 0; i < 6; i++) wa[i] = 8'(i + 1);
    feed_a("t1", -1);
    check_a_load("t1", base, dbase, 48'h060504030201);
  endtask

  task automatic test_partial_word();
    int t, base;
    logic [12:0] g;
    logic [W-1:0] wb [0:1];
    wb[0] = 8'hFF; wb[1] = 8'hD5;
    base = b_nshift;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_s_data = wb[i];
      b_s_valid = 1'b1;
      t = 0;
      while (b_s_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      b_s_valid = 1'b0;
    end
    t = 0;
    while (b_done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    n_chk++;
    if (t >= 100) $display("FAIL t2_done: no done within 100 cycles");
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (b_nshift - base !== 13) $display("FAIL t2_shift_count: got %0d want 13", b_nshift - base);
    else n_pass++;
    for (int k = 0; k < 13; k++) g[k] = b_log[(base + k) % 64];
    n_chk++;
    if (g !== 13'h15FF) $display("FAIL t2_head_order: got %h want 15ff", g);
    else n_pass++;
    n_chk++;
    if ({b_busy, b_s_ready, b_ndone} !== {2'b00, 32'sd1})
      $display("FAIL t2_idle_after: busy=%b ready=%b dones=%0d want 0 0 1", b_busy, b_s_ready, b_ndone);
    else n_pass++;
  endtask

  task automatic test_gap();
    int base, dbase;
    base = a_nshift; dbase = a_ndone;
    for (int i = 0; i < 6; i++) wa[i] = 8'(8'h11 * (i + 1));
    feed_a("t3", 2);
    check_a_load("t3", base, dbase, 48'h665544332211);
  endtask

  task automatic test_abort();
    int t, base, dbase;
    base = a_nshift; dbase = a_ndone;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_s_data = 8'h3C;
    a_s_valid = 1'b1;
    t = 0;
    while ((a_nshift - base) < 19 && t < 200) begin @(negedge clk); t++; end
    n_chk++;
    if (a_shift_en !== 1'b1) $display("FAIL t4_pre_abort: shift_en=%b want 1", a_shift_en);
    else n_pass++;
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    a_s_valid = 1'b0;
    n_chk++;
    if ({a_shift_en, a_busy, a_s_ready, a_done} !== 4'b0000)
      $display("FAIL t4_abort_idle: shift_en,busy,ready,done=%b want 0000",
               {a_shift_en, a_busy, a_s_ready, a_done});
    else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++;
    if (a_nshift - base !== 20) $display("FAIL t4_abort_shifts: got %0d want 20", a_nshift - base);
    else n_pass++;
    n_chk++;
    if (a_ndone !== dbase) $display("FAIL t4_no_done: got %0d dones want 0", a_ndone - dbase);
    else n_pass++;
    base = a_nshift; dbase = a_ndone;
    for (int i = 0; i < 6; i++) wa[i] = 8'(8'hA1 + i);
    feed_a("t4b", -1);
    check_a_load("t4b", base, dbase, 48'hA6A5A4A3A2A1);
  endtask

  task automatic test_reset_mid();
    int t;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_s_data = 8'hFF;
    a_s_valid = 1'b1;
    t = 0;
    while (a_shift_en !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    n_chk++;
    if ({a_shift_en, a_head} !== 2'b11) $display("FAIL t5_shifting: shift_en,head=%b want 11", {a_shift_en, a_head});
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({a_s_ready, a_head, a_shift_en, a_busy, a_done, a_rb_valid} !== 6'b0)
      $display("FAIL t5_reset_mid: got %b want 000000",
               {a_s_ready, a_head, a_shift_en, a_busy, a_done, a_rb_valid});
    else n_pass++;
    rst = 1'b0;
    a_s_valid = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_abort = 1'b0;
    n_chk++;
    if ({a_busy, a_s_ready} !== 2'b00) $display("FAIL t5_abort_wins: busy,ready=%b want 00", {a_busy, a_s_ready});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (a_busy !== 1'b0) $display("FAIL t5_stays_idle: busy=%b want 0", a_busy);
    else n_pass++;
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_readback();
    int rbase;
    logic [47:0] g;
    logic [W-1:0] pat;
    for (int j = 0; j < 6; j++) begin
      pat = (j % 2 == 0) ? 8'hA5 : 8'hC3;
      for (int k = 0; k < 8; k++) pre_val[47 - (8 * j + k)] = pat[k];
    end
    pre_req = 1'b1;
    @(negedge clk);
    pre_req = 1'b0;
    rbase = a_nrb;
    for (int i = 0; i < 6; i++) wa[i] = 8'(8'h11 * (i + 1));
    feed_a("t6a", -1);
    n_chk++;
    if (a_nrb - rbase !== 6) $display("FAIL t6_rb_count: got %0d want 6", a_nrb - rbase);
    else n_pass++;
    for (int j = 0; j < 6; j++) g[8 * j +: 8] = a_rb_log[(rbase + j) % 64];
    n_chk++;
    if (g !== 48'hC3A5C3A5C3A5) $display("FAIL t6_rb_old: got %h want c3a5c3a5c3a5", g);
    else n_pass++;
    rbase = a_nrb;
    for (int i = 0; i < 6; i++) wa[i] = 8'(8'h5A ^ i);
    feed_a("t6b", -1);
    for (int j = 0; j < 6; j++) g[8 * j +: 8] = a_rb_log[(rbase + j) % 64];
    n_chk++;
    if (a_nrb - rbase !== 6 || g !== 48'h665544332211)
      $display("FAIL t6_rb_new: got %0d words %h want 6 words 665544332211", a_nrb - rbase, g);
    else n_pass++;
  endtask
`else
  task automatic test_readback();
    n_chk++;
    if (a_nrb + b_nrb !== 0 || a_rb_data !== 8'h00 || b_rb_data !== 8'h00)
      $display("FAIL rb_disabled: pulses=%0d rb_a=%h rb_b=%h want 0 00 00", a_nrb + b_nrb, a_rb_data, b_rb_data);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_partial_word();
    test_gap();
    test_abort();
    test_reset_mid();
    test_readback();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
